// File: rtl/run_step_ctrl.sv
// run_step_ctrl
//   Consumer end of the front-panel "go" button path. The raw button is
//   synchronised and debounced into one clean go_pulse per press. That pulse
//   starts the CPU in free-run mode, or issues a single step, through cpu_en.
//   A halt request from the CPU (syscall halt) stops a free run, and each such
//   stop is counted in halt_cnt.
//
//   Optional build macro: GO_AUTOREPEAT_EN. When it is defined, holding the
//   button re-issues go_pulse every REPEAT_CYCLES cycles.
//
//   Ports
//     clk        system clock, single domain
//     rst        synchronous active-low reset
//     go         raw button, asynchronous and bouncy
//     step_mode  1 = single-step, 0 = free run (quasi-static)
//     halt_req   CPU halt request, level, synchronous to clk
//     cpu_en     CPU clock enable, decoded from the state register
//     running    1 while in RUN
//     go_pulse   one-cycle debounced press event
//     halt_cnt   number of RUN->HALT transitions caused by halt_req
//
//   state | meaning
//   ------+--------------------------------------------------
//   HALT  | CPU stopped, waiting for go_pulse
//   RUN   | CPU free-running until halt_req or a step-mode press
//   STEP  | CPU enabled for exactly one cycle, then HALT
module run_step_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          CNT_W           = 16,
    parameter logic [31:0] REPEAT_CYCLES   = 32'd25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             step_mode,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             go_pulse,
    output logic [CNT_W-1:0] halt_cnt
);

    if (DEBOUNCE_CYCLES == 16'd0 || REPEAT_CYCLES == 32'd0) begin : g_param_check
        $error("run_step_ctrl: DEBOUNCE_CYCLES and REPEAT_CYCLES must be nonzero");
    end

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        go_s1;
    logic        go_s2;
    logic        go_db;
    logic        go_db_q;
    logic [15:0] db_cnt;
    logic        pulse_nxt;
    logic        halt_inc;

    // Two-flop synchroniser; nothing else looks at go.
    always_ff @(posedge clk) begin
        if (!rst) begin
            go_s1 <= 1'b0;
            go_s2 <= 1'b0;
        end else begin
            go_s1 <= go;
            go_s2 <= go_s1;
        end
    end

    // The debounced level flips only after the synchronised input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_cnt  <= '0;
            go_db   <= 1'b0;
            go_db_q <= 1'b0;
        end else begin
            go_db_q <= go_db;
            if (go_s2 == go_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                go_db  <= ~go_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

`ifdef GO_AUTOREPEAT_EN
    logic [31:0] rep_cnt;
    logic        held;
    logic        rep_hit;

    // held is false on the rising-edge cycle, so the first repeat comes a full
    // REPEAT_CYCLES after the initial pulse.
    assign held    = go_db & go_db_q;
    assign rep_hit = held && (rep_cnt == REPEAT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst || !held || rep_hit) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 32'd1;
        end
    end

    assign pulse_nxt = (go_db & ~go_db_q) | rep_hit;
`else
    assign pulse_nxt = go_db & ~go_db_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            go_pulse <= 1'b0;
        end else begin
            go_pulse <= pulse_nxt;
        end
    end

    // Halt takes priority over a step-mode press arriving in the same cycle.
    assign halt_inc = (state == S_RUN) && halt_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_HALT;
            halt_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (halt_inc) begin
                halt_cnt <= halt_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (go_pulse) begin
                    state_nxt = step_mode ? S_STEP : S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (go_pulse && step_mode) begin
                    state_nxt = S_HALT;
                end
            end
            S_STEP:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        cpu_en  = 1'b0;
        running = 1'b0;
        case (state)
            S_RUN: begin
                cpu_en  = 1'b1;
                running = 1'b1;
            end
            S_STEP:  cpu_en = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_run_step_ctrl.sv
module tb_run_step_ctrl;

    localparam int D     = 4;
    localparam int R     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic             step_mode;
    logic             halt_req;
    logic             cpu_en;
    logic             running;
    logic             go_pulse;
    logic [CNT_W-1:0] halt_cnt;

    int n_vec = 0;
    int n_err = 0;

    run_step_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .CNT_W          (CNT_W),
        .REPEAT_CYCLES  (32'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .step_mode(step_mode),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .running  (running),
        .go_pulse (go_pulse),
        .halt_cnt (halt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model, written in terms of the observable rules: go is seen
    // two edges late, the debounced level flips once the last D seen samples
    // all disagree with it, a press event follows one cycle after a rise.
    logic m_g1, m_g2, m_deb, m_rose, m_pulse, m_run, m_step;
    logic win[$];
    int   m_age;
    int   m_cnt;

    task automatic model_step();
        logic pulse_pre, new_pulse, s, all_diff;
        if (!rst) begin
            m_g1 = 0; m_g2 = 0; m_deb = 0; m_rose = 0; m_pulse = 0;
            m_run = 0; m_step = 0; m_age = 0; m_cnt = 0;
            win.delete();
            return;
        end
        pulse_pre = m_pulse;
        if (m_step) begin
            m_step = 0;
        end else if (m_run) begin
            if (halt_req) begin
                m_run = 0;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end else if (pulse_pre && step_mode) begin
                m_run = 0;
            end
        end else if (pulse_pre) begin
            if (step_mode) m_step = 1;
            else           m_run  = 1;
        end
        new_pulse = m_rose;
        if (m_rose) begin
            m_age = 0;
        end else if (m_deb) begin
            m_age++;
`ifdef GO_AUTOREPEAT_EN
            if (m_age % R == 0) new_pulse = 1;
`endif
        end
        s = m_g2; m_g2 = m_g1; m_g1 = go;
        win.push_back(s);
        if (win.size() > D) void'(win.pop_front());
        m_rose = 0;
        if (win.size() == D) begin
            all_diff = 1;
            foreach (win[i]) if (win[i] == m_deb) all_diff = 0;
            if (all_diff) begin
                m_deb  = ~m_deb;
                m_rose = m_deb;
            end
        end
        m_pulse = new_pulse;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    int acc_en, acc_pulse, acc_run, cyc, first_pulse;

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model.go_pulse", 32'(go_pulse), 32'(m_pulse));
        chk("model.cpu_en",   32'(cpu_en),   32'(m_run | m_step));
        chk("model.running",  32'(running),  32'(m_run));
        chk("model.halt_cnt", 32'(halt_cnt), 32'(m_cnt));
        acc_en    += int'(cpu_en);
        acc_pulse += int'(go_pulse);
        acc_run   += int'(running);
        if (go_pulse === 1'b1 && first_pulse < 0) first_pulse = cyc;
        cyc++;
    endtask

    task automatic clr_acc();
        acc_en = 0; acc_pulse = 0; acc_run = 0; cyc = 0; first_pulse = -1;
    endtask

    task automatic press(input int hold, input int rel);
        go = 1;
        repeat (hold) tick();
        go = 0;
        repeat (rel) tick();
    endtask

    typedef struct {
        logic r, g, s, h;
        logic p, e, u;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic g,
                       input logic p, input logic e, input logic u);
        vec_t v;
        v.r = r; v.g = g; v.s = 1'b1; v.h = 1'b0;
        v.p = p; v.e = e; v.u = u;
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        int exp_p;
        rst = 0; go = 1; step_mode = 1; halt_req = 0;
        clr_acc();

        // Reset with go held, first press, step, release, bounce, second press.
        add(2, 0, 1, 0, 0, 0);
        add(6, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0);
        add(9, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(6, 1, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 1, 0);
        add(8, 1, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; go = tbl[i].g; step_mode = tbl[i].s; halt_req = tbl[i].h;
            tick();
            chk($sformatf("tbl[%0d].go_pulse", i), 32'(go_pulse), 32'(tbl[i].p));
            chk($sformatf("tbl[%0d].cpu_en", i),   32'(cpu_en),   32'(tbl[i].e));
            chk($sformatf("tbl[%0d].running", i),  32'(running),  32'(tbl[i].u));
            chk($sformatf("tbl[%0d].halt_cnt", i), 32'(halt_cnt), 0);
        end

        // Three clean single-step presses.
        step_mode = 1;
        clr_acc();
        repeat (3) press(8, 8);
        chk("step.cpu_en_cycles", acc_en, 3);
        chk("step.running_cycles", acc_run, 0);
        chk("step.pulses", acc_pulse, 3);

        // Free run stopped by halt_req, 16 times so the counter wraps.
        step_mode = 0;
        for (int k = 0; k < 16; k++) begin
            press(8, 8);
            chk("runhalt.running", 32'(running), 1);
            chk("runhalt.cpu_en", 32'(cpu_en), 1);
            halt_req = 1;
            tick();
            halt_req = 0;
            chk("runhalt.cpu_en_after", 32'(cpu_en), 0);
            chk("runhalt.halt_cnt", 32'(halt_cnt), (k + 1) % 16);
        end

        // Step-mode press coinciding with halt_req while running.
        press(8, 8);
        chk("sim.running", 32'(running), 1);
        step_mode = 1;
        go = 1;
        repeat (7) tick();
        chk("sim.go_pulse", 32'(go_pulse), 1);
        halt_req = 1;
        tick();
        halt_req = 0;
        chk("sim.cpu_en", 32'(cpu_en), 0);
        chk("sim.running", 32'(running), 0);
        chk("sim.halt_cnt", 32'(halt_cnt), 1);
        go = 0;
        repeat (8) tick();
        chk("sim.stays_halted", 32'(cpu_en), 0);

        // Reset while running, then reset during a step.
        step_mode = 0;
        press(8, 8);
        chk("rstrun.running_before", 32'(running), 1);
        rst = 0;
        tick();
        chk("rstrun.cpu_en", 32'(cpu_en), 0);
        chk("rstrun.running", 32'(running), 0);
        chk("rstrun.halt_cnt", 32'(halt_cnt), 0);
        rst = 1;
        step_mode = 1;
        go = 1;
        repeat (8) tick();
        chk("rststep.cpu_en_before", 32'(cpu_en), 1);
        chk("rststep.running_before", 32'(running), 0);
        go = 0;
        rst = 0;
        tick();
        chk("rststep.cpu_en", 32'(cpu_en), 0);
        chk("rststep.go_pulse", 32'(go_pulse), 0);
        rst = 1;
        repeat (8) tick();

        // Long hold in step mode.
        clr_acc();
        go = 1;
        repeat (30) tick();
        go = 0;
        repeat (15) tick();
`ifdef GO_AUTOREPEAT_EN
        exp_p = 4;
`else
        exp_p = 1;
`endif
        chk("hold.first_pulse", first_pulse, 6);
        chk("hold.pulses", acc_pulse, exp_p);
        chk("hold.steps", acc_en, exp_p);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) go = ~go;
            if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
            halt_req = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
